coin_credit_unit: RTL and testbench
===================================

// Module: coin_credit_unit
// PURPOSE
//  Coin front end directly upstream of the water vending FSM. Accepts typed coin events, accumulates
//  credit in cents, raises the downstream 'coin' request once credit >= PRICE, and tracks the
//  downstream status to know when the vend completes. It then deducts PRICE and pays change, or
//  refunds on request, as one nickel pulse per CHANGE_UNIT.
// PARAMETERS
//  PRICE      75  vend price in cents; multiple of 5; elaboration error if PRICE+95 > 2**CREDIT_W-1
//  CREDIT_W   8   width of credit register (cents)
//  PULSE_GAP  2   change pulse period in cycles (>=2): 1 cycle high, PULSE_GAP-1 low
// PORTS
//  clk          in   1         clock, all logic on rising edge
//  reset        in   1         synchronous, active-high
//  coin_valid   in   1         one-cycle strobe: a coin is present
//  coin_type    in   2         00=5c 01=10c 10=25c 11=100c; valid only with coin_valid
//  refund_req   in   1         level/pulse; request return of current credit
//  vend_status  in   2         downstream state: 00 IDLE 01 COIN_INSERTED 10 DISPENSE 11 COMPLETE
//  coin_out     out  1         level request to downstream 'coin' input
//  coin_reject  out  1         one-cycle pulse: coin not credited (physically returned)
//  change_pulse out  1         one-cycle pulse per 5c returned
//  credit       out  CREDIT_W  current credit, cents (registered)
//  busy         out  1         high whenever state != COLLECT
// BEHAVIOUR
//  Reset: state=COLLECT, credit=0. coin_out, coin_reject, change_pulse and busy are all 0.
//  Reset mid-operation aborts immediately. No change is owed or paid, and the pulse timer clears.
//  All outputs are registered. Coin at edge N: credit updates at N+1.
//  COLLECT: coin_valid adds value(coin_type) to credit.
//   - If credit is >= PRICE after an add, go to ARMED. coin_out=1 from the same edge (N+1).
//   - refund_req && credit>0 -> REFUND. refund_req && credit==0 -> ignored.
//   - coin_valid together with refund_req: refund wins. The coin gets coin_reject and is not credited.
//  ARMED: hold coin_out=1 until vend_status!=00 is sampled, then coin_out=0 on the next edge.
//   - Stay in ARMED until vend_status==11 is sampled. Then credit <= credit-PRICE, go to CHANGE.
//   - refund_req is ignored in ARMED. The downstream FSM cannot abort a vend.
//  CHANGE/REFUND (shared datapath): while credit>0, emit change_pulse every PULSE_GAP cycles.
//   - The first pulse comes on the first cycle in the state. Each pulse does credit -= 5.
//   - When credit==0 and no pulse is pending, go to COLLECT. credit==0 on entry -> COLLECT next edge, no pulses.
//  coin_valid in ARMED/CHANGE/REFUND: coin_reject pulse at N+1, credit unchanged.
//  Overflow cannot occur: max credit in COLLECT is PRICE-5+100, guaranteed by the parameter check.
//  Credit stays a multiple of 5. Subtraction never underflows: credit>=PRICE in ARMED.
//  busy=1 in ARMED, CHANGE and REFUND.
// STRUCTURE
//  Shared package vend_pkg holds:
//   - coin_type encodings and the value-in-cents function
//   - vend status encodings (IDLE/COIN_INSERTED/DISPENSE_WATER/DISPENSE_COMPLETE), shared with the vending FSM
//   - the CHANGE_UNIT=5 constant
//  Sub-module change_pulser: start/credit-remaining in, change_pulse/dec/done out.
//   - Contains the PULSE_GAP timer.
// TESTING (PRICE=75, PULSE_GAP=2, downstream FSM model or the real vending FSM attached)
//  1 quarter x3 -> credit 25/50/75; coin_out=1 the cycle after 3rd; after status 11 credit=0, no change_pulse, busy=0
//  2 one 100c coin -> ARMED at once; after vend credit=25 -> 5 change_pulse on alternate cycles, credit 0
//  3 10c+5c then refund_req -> REFUND, 3 pulses, credit 0; 25c inserted during refund -> coin_reject, credit unaffected
//  4 25c coin while ARMED/dispensing -> coin_reject 1 cycle, credit stays 75, vend completes normally
//  5 coin_valid and refund_req same cycle with credit 10 -> coin rejected, 2 change pulses, credit 0
//  6 reset asserted mid-CHANGE (credit 15) -> next cycle credit=0, all outputs 0, state COLLECT

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the coin front end and the water vending FSM:
// coin encodings with their cent values, the downstream status encoding,
// and the size of one unit of returned change.
package vend_pkg;

    // Physical coin types reported by the acceptor mechanism
    typedef enum logic [1:0] {
        COIN_5   = 2'b00,
        COIN_10  = 2'b01,
        COIN_25  = 2'b10,
        COIN_100 = 2'b11
    } coin_type_e;

    // Vending FSM state as seen on its status output
    typedef enum logic [1:0] {
        VS_IDLE              = 2'b00,
        VS_COIN_INSERTED     = 2'b01,
        VS_DISPENSE_WATER    = 2'b10,
        VS_DISPENSE_COMPLETE = 2'b11
    } vend_status_e;

    // Every change pulse hands back one nickel
    localparam int CHANGE_UNIT = 5;

    // Width large enough to hold the largest coin value
    localparam int COIN_VALUE_W = 7;

    // Value in cents of a coin type
    function automatic logic [COIN_VALUE_W-1:0] coin_value(input coin_type_e t);
        logic [COIN_VALUE_W-1:0] v;
        case (t)
            COIN_5:   v = 7'd5;
            COIN_10:  v = 7'd10;
            COIN_25:  v = 7'd25;
            COIN_100: v = 7'd100;
            default:  v = 7'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_credit_unit_if.sv
// Bundle of the coin acceptor, refund button and downstream vending FSM
// signals seen by the coin credit unit. The master side is whoever drives
// coins, refunds and vend status; the slave side is the credit unit itself.
interface coin_credit_unit_if #(
    parameter int CREDIT_W = 8
);

    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                refund_req;
    logic [1:0]          vend_status;

    logic                coin_out;
    logic                coin_reject;
    logic                change_pulse;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin_valid,
        output coin_type,
        output refund_req,
        output vend_status,
        input  coin_out,
        input  coin_reject,
        input  change_pulse,
        input  credit,
        input  busy
    );

    modport slave (
        input  coin_valid,
        input  coin_type,
        input  refund_req,
        input  vend_status,
        output coin_out,
        output coin_reject,
        output change_pulse,
        output credit,
        output busy
    );

endinterface

// File: rtl/change_pulser.sv
// Paces the return of credit as nickel pulses. A start strobe arms it with
// the credit to be paid out; it then raises one pulse every PULSE_GAP
// cycles, the first one in the cycle right after the start, while credit
// remains. Each pulse also tells the owner to take one nickel off the
// credit register. Done is reported once credit has reached zero and no
// pulse is in flight.
module change_pulser
    import vend_pkg::*;
#(
    parameter int CREDIT_W  = 8,
    parameter int PULSE_GAP = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [CREDIT_W-1:0] i_credit,
    output logic                o_change_pulse,
    output logic                o_dec,
    output logic                o_done
);

    localparam int TIMER_W = (PULSE_GAP > 2) ? $clog2(PULSE_GAP) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PULSE_GAP - 1);

    logic               r_active;
    logic               r_pulse;
    logic [TIMER_W-1:0] r_timer;
    logic               w_done;
    logic               w_credit_left;

    assign w_credit_left = (i_credit != '0);
    assign w_done        = r_active && !w_credit_left && !r_pulse;

    // Pulse pacing: the timer gives the position inside the current pulse period
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_pulse  <= 1'b0;
            r_timer  <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_pulse  <= w_credit_left;
            r_timer  <= '0;
        end else if (r_active) begin
            if (w_done) begin
                r_active <= 1'b0;
                r_pulse  <= 1'b0;
                r_timer  <= '0;
            end else begin
                r_timer <= (r_timer == TIMER_LAST) ? '0 : r_timer + 1'b1;
                r_pulse <= (r_timer == TIMER_LAST) && w_credit_left;
            end
        end else begin
            r_pulse <= 1'b0;
            r_timer <= '0;
        end
    end

    assign o_change_pulse = r_pulse;
    assign o_dec          = r_pulse;
    assign o_done         = w_done;

endmodule

// File: rtl/coin_credit_unit.sv
// Coin front end sitting just upstream of the water vending FSM. Coins are
// accumulated as credit in cents; once the price is covered the downstream
// 'coin' request is raised and held until the vending FSM leaves IDLE. When
// the vend completes the price is deducted and any remainder is paid back
// as nickel pulses; a refund request pays back the whole credit the same
// way. Coins that arrive while the unit is busy are rejected.
module coin_credit_unit
    import vend_pkg::*;
#(
    parameter int PRICE     = 75,
    parameter int CREDIT_W  = 8,
    parameter int PULSE_GAP = 2
) (
    input  logic               clk,
    input  logic               reset,
    coin_credit_unit_if.slave  bus
);

    // Parameter sanity: the credit register must hold a coin of 100 on top
    // of the largest sub-price credit, and change is paid in whole nickels
    if ((PRICE + 95) > ((1 << CREDIT_W) - 1)) begin : g_credit_too_narrow
        $error("coin_credit_unit: CREDIT_W too small for PRICE");
    end
    if ((PRICE % CHANGE_UNIT) != 0) begin : g_price_not_nickel
        $error("coin_credit_unit: PRICE must be a multiple of 5");
    end
    if (PRICE <= 0) begin : g_price_not_positive
        $error("coin_credit_unit: PRICE must be positive");
    end
    if (PULSE_GAP < 2) begin : g_gap_too_short
        $error("coin_credit_unit: PULSE_GAP must be at least 2");
    end

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CHANGE  = 2'd2;
    localparam logic [1:0] ST_REFUND  = 2'd3;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);

    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_coin_out;
    logic                r_coin_reject;
    logic                r_busy;

    logic [1:0]          w_next_state;
    logic [CREDIT_W-1:0] w_coin_value;
    logic [CREDIT_W-1:0] w_credit_sum;
    logic                w_refund_go;
    logic                w_coin_accept;
    logic                w_price_met;
    logic                w_vend_started;
    logic                w_vend_complete;
    logic                w_start;
    logic [CREDIT_W-1:0] w_entry_credit;
    logic [CREDIT_W-1:0] w_pulser_credit;
    logic                w_change_pulse;
    logic                w_dec;
    logic                w_done;

    assign w_coin_value    = CREDIT_W'(coin_value(coin_type_e'(bus.coin_type)));
    assign w_credit_sum    = r_credit + w_coin_value;
    assign w_price_met     = (w_credit_sum >= PRICE_C);
    assign w_vend_started  = (bus.vend_status != VS_IDLE);
    assign w_vend_complete = (bus.vend_status == VS_DISPENSE_COMPLETE);

    // A refund only means something when there is credit to hand back; a
    // coin arriving together with a live refund is returned, not credited
    assign w_refund_go   = (r_state == ST_COLLECT) && bus.refund_req && (r_credit != '0);
    assign w_coin_accept = (r_state == ST_COLLECT) && bus.coin_valid && !w_refund_go;

    // Next state plus the start strobe and entry credit for the change pulser
    always_comb begin
        w_next_state   = r_state;
        w_start        = 1'b0;
        w_entry_credit = r_credit;
        case (r_state)
            ST_COLLECT: begin
                if (w_refund_go) begin
                    w_next_state   = ST_REFUND;
                    w_start        = 1'b1;
                    w_entry_credit = r_credit;
                end else if (w_coin_accept && w_price_met) begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_vend_complete) begin
                    w_next_state   = ST_CHANGE;
                    w_start        = 1'b1;
                    w_entry_credit = r_credit - PRICE_C;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                if (w_done) begin
                    w_next_state = ST_COLLECT;
                end
            end
            default: begin
                w_next_state = ST_COLLECT;
            end
        endcase
    end

    // The pulser sees the entry credit on the start cycle and the live credit afterwards
    assign w_pulser_credit = w_start ? w_entry_credit : r_credit;

    change_pulser #(
        .CREDIT_W  (CREDIT_W),
        .PULSE_GAP (PULSE_GAP)
    ) u_change_pulser (
        .clk            (clk),
        .reset          (reset),
        .i_start        (w_start),
        .i_credit       (w_pulser_credit),
        .o_change_pulse (w_change_pulse),
        .o_dec          (w_dec),
        .o_done         (w_done)
    );

    // State register and the busy flag that mirrors it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_COLLECT;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_COLLECT);
        end
    end

    // Credit: coins add, the vend deducts the price, each change pulse takes a nickel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit <= '0;
        end else if (w_coin_accept) begin
            r_credit <= w_credit_sum;
        end else if (w_start) begin
            r_credit <= w_entry_credit;
        end else if (w_dec) begin
            r_credit <= r_credit - UNIT_C;
        end
    end

    // Downstream coin request: raised with the covering coin, dropped once the vend FSM reacts
    always_ff @(posedge clk) begin
        if (reset) begin
            r_coin_out <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: r_coin_out <= w_coin_accept && w_price_met;
                ST_ARMED:   r_coin_out <= r_coin_out && !w_vend_started;
                default:    r_coin_out <= 1'b0;
            endcase
        end
    end

    // Any coin that is not credited is physically returned with a one-cycle reject pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_coin_reject <= 1'b0;
        end else begin
            r_coin_reject <= bus.coin_valid && !w_coin_accept;
        end
    end

    assign bus.coin_out     = r_coin_out;
    assign bus.coin_reject  = r_coin_reject;
    assign bus.change_pulse = w_change_pulse;
    assign bus.credit       = r_credit;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_coin_credit_unit.sv
// Bench for the coin credit unit: directed scenarios followed by random
// traffic. A reference model predicts all outputs after every edge and
// queues them; an independent monitor compares the DUT against the queue.
module tb_coin_credit_unit;

    localparam int PRICE     = 75;
    localparam int CREDIT_W  = 8;
    localparam int PULSE_GAP = 2;

    logic clk = 1'b0;
    logic reset;

    coin_credit_unit_if #(.CREDIT_W(CREDIT_W)) bus ();

    coin_credit_unit #(
        .PRICE     (PRICE),
        .CREDIT_W  (CREDIT_W),
        .PULSE_GAP (PULSE_GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int credit;
        bit coinOut;
        bit reject;
        bit pulse;
        bit busy;
    } expect_t;

    expect_t expQ[$];
    int errors = 0;
    int checks = 0;

    int coinValue [4] = '{5, 10, 25, 100};

    // Reference model: phase 0 collecting, 1 waiting for the vend, 2 paying out
    int mPhase   = 0;
    int mCredit  = 0;
    bit mCoinOut = 0;
    int mPayC    = 0;
    int mPayAge  = 0;

    // Credit still shown at a given age of a payout that began with c cents
    function automatic int payCredit(int c, int age);
        int n;
        int paid;
        n    = c / 5;
        paid = (age == 0) ? 0 : ((age - 1) / PULSE_GAP + 1);
        if (paid > n) paid = n;
        return c - 5 * paid;
    endfunction

    // Number of cycles a payout of c cents stays busy
    function automatic int payLen(int c);
        int n;
        n = c / 5;
        return (n == 0) ? 1 : (n - 1) * PULSE_GAP + 2;
    endfunction

    task automatic startPay(int c);
        mPhase   = 2;
        mPayC    = c;
        mPayAge  = 0;
        mCoinOut = 0;
    endtask

    // Advance the model by one edge and queue the outputs it predicts
    task automatic modelStep(bit rst, bit cv, int ct, bit rr, int vs);
        expect_t e;
        bit rej;
        rej = 0;
        if (rst) begin
            mPhase   = 0;
            mCredit  = 0;
            mCoinOut = 0;
        end else begin
            case (mPhase)
                0: begin
                    if (rr && mCredit > 0) begin
                        rej = cv;
                        startPay(mCredit);
                    end else if (cv) begin
                        mCredit = mCredit + coinValue[ct];
                        if (mCredit >= PRICE) begin
                            mPhase   = 1;
                            mCoinOut = 1;
                        end
                    end
                end
                1: begin
                    rej = cv;
                    if (vs != 0) mCoinOut = 0;
                    if (vs == 3) startPay(mCredit - PRICE);
                end
                default: begin
                    rej = cv;
                    mPayAge = mPayAge + 1;
                    if (mPayAge >= payLen(mPayC)) begin
                        mPhase  = 0;
                        mCredit = 0;
                    end
                end
            endcase
        end
        e.credit  = (mPhase == 2) ? payCredit(mPayC, mPayAge) : mCredit;
        e.coinOut = mCoinOut;
        e.reject  = rej;
        e.pulse   = (mPhase == 2) && (mPayAge % PULSE_GAP == 0) && (mPayAge / PULSE_GAP < mPayC / 5);
        e.busy    = (mPhase != 0);
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs and let the model predict the result
    task automatic applyStimulus(bit rst, bit cv, int ct, bit rr, int vs);
        @(negedge clk);
        reset           = rst;
        bus.coin_valid  = cv;
        bus.coin_type   = 2'(ct);
        bus.refund_req  = rr;
        bus.vend_status = 2'(vs);
        modelStep(rst, cv, ct, rr, vs);
    endtask

    task automatic idle(int n, int vs);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, vs);
    endtask

    task automatic insertCoin(int ct);
        applyStimulus(0, 1, ct, 0, 0);
    endtask

    // Compare one predicted output set against what the DUT shows
    task automatic checkOutput(expect_t e);
        checks++;
        if (int'(bus.credit) != e.credit || bus.coin_out !== e.coinOut ||
            bus.coin_reject !== e.reject || bus.change_pulse !== e.pulse ||
            bus.busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL outputs at check %0d (t=%0t): got credit=%0d coin_out=%b reject=%b pulse=%b busy=%b, expected credit=%0d coin_out=%b reject=%b pulse=%b busy=%b",
                     checks, $time, bus.credit, bus.coin_out, bus.coin_reject, bus.change_pulse, bus.busy,
                     e.credit, e.coinOut, e.reject, e.pulse, e.busy);
        end
    endtask

    // Monitor: after every edge, pop the prediction made for it and compare
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.coin_valid  = 1'b0;
        bus.coin_type   = 2'b00;
        bus.refund_req  = 1'b0;
        bus.vend_status = 2'b00;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);

        $display("[TB] three quarters then a full vend");
        insertCoin(2); insertCoin(2); insertCoin(2);
        idle(2, 0); idle(2, 1); idle(2, 2); idle(1, 3); idle(4, 0);

        $display("[TB] dollar coin with 25c change");
        insertCoin(3);
        idle(1, 0); idle(1, 1); idle(1, 2); idle(1, 3); idle(14, 0);

        $display("[TB] refund of 15c with a coin during refund");
        insertCoin(1); insertCoin(0);
        applyStimulus(0, 0, 0, 1, 0);
        insertCoin(2);
        idle(8, 0);

        $display("[TB] coins rejected while armed and dispensing");
        insertCoin(2); insertCoin(2); insertCoin(2);
        insertCoin(2);
        applyStimulus(0, 1, 2, 0, 1);
        applyStimulus(0, 1, 2, 0, 2);
        idle(1, 3); idle(4, 0);

        $display("[TB] coin together with refund");
        insertCoin(1);
        applyStimulus(0, 1, 2, 1, 0);
        idle(6, 0);

        $display("[TB] reset in the middle of paying change");
        insertCoin(3);
        idle(1, 1); idle(1, 3);
        idle(3, 0);
        applyStimulus(1, 0, 0, 0, 0);
        idle(3, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            bit cv;
            bit rr;
            int ct;
            int vs;
            rst = ($urandom_range(0, 299) == 0);
            cv  = ($urandom_range(0, 2) == 0);
            ct  = $urandom_range(0, 3);
            rr  = ($urandom_range(0, 9) == 0);
            vs  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            applyStimulus(rst, cv, ct, rr, vs);
        end
        idle(2, 0);

        @(posedge clk);
        #3;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
